// File: rtl/voice_slot_pkg.sv
// rtl/voice_slot_pkg.sv - shared constants and types for the voice slot scheduler
package voice_slot_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int DATA_W    = 59;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HACK = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  typedef logic [3:0] slot_t;

endpackage

// File: rtl/voice_slot_sched.sv
// rtl/voice_slot_sched.sv - per-voice state RAM sweep scheduler with host port; VOICE_MASK_EN adds per-slot update mask
module voice_slot_sched
  import voice_slot_pkg::*;
#(
  parameter int NUM_SLOTS = voice_slot_pkg::NUM_SLOTS,
  parameter int DATA_W    = voice_slot_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_stb,
  output logic [3:0]        o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic [DATA_W-1:0] o_upd_cur,
  output logic [3:0]        o_upd_slot,
  output logic              o_upd_stb,
  input  logic [DATA_W-1:0] i_upd_next,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [3:0]        i_host_slot,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun,
  input  logic              i_overrun_clr
`ifdef VOICE_MASK_EN
  ,
  input  logic [15:0]       i_slot_active
`endif
);

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  slot_t             r_slot;
  slot_t             w_slot_nxt;
  logic              r_pend;
  logic              w_pend_nxt;
  logic [DATA_W-1:0] r_upd_cur;
  slot_t             r_upd_slot;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_frame_done;
  logic              r_overrun;

  logic              w_go;
  logic              w_host_grant;
  logic              w_slot_on;
  logic              w_ovr_evt;

  // A deferred request (r_pend) starts a sweep exactly like a live strobe.
  // No present path sets it, so it only ever clears; the start logic honours it.
  assign w_go = i_sample_stb | r_pend;

  // Host is served only from IDLE with no sweep waiting; held off during reset
  // so the RAM keeps rewriting its own output at the slot address.
  assign w_host_grant = (r_state == IDLE) & ~w_go & i_host_req & i_rst_n;

  // Strobes landing in HACK or IDLE start a sweep; only RD/WR count as busy.
  assign w_ovr_evt = i_sample_stb & o_busy;

`ifdef VOICE_MASK_EN
  assign w_slot_on = i_slot_active[r_slot];
`else
  assign w_slot_on = 1'b1;
`endif

  // Next-state logic and the RAM port mux; default is a hold-write of ram_dout.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_pend_nxt  = r_pend;
    o_ram_addr  = r_slot;
    o_ram_din   = i_ram_dout;
    o_upd_stb   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nxt = RD;
          w_slot_nxt  = '0;
          w_pend_nxt  = 1'b0;
        end else if (w_host_grant) begin
          o_ram_addr  = i_host_slot;
          o_ram_din   = i_host_we ? i_host_wdata : i_ram_dout;
          w_state_nxt = HACK;
        end
      end
      HACK: begin
        if (w_go) begin
          w_state_nxt = RD;
          w_slot_nxt  = '0;
          w_pend_nxt  = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD: begin
        w_state_nxt = WR;
      end
      WR: begin
        if (w_slot_on) begin
          o_ram_din = i_upd_next;
          o_upd_stb = 1'b1;
        end else begin
          o_ram_din = r_upd_cur;
        end
        if (r_slot == LAST_SLOT) begin
          w_state_nxt = IDLE;
          w_slot_nxt  = '0;
        end else begin
          w_state_nxt = RD;
          w_slot_nxt  = r_slot + slot_t'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_slot_nxt  = '0;
      end
    endcase
  end

  // FSM state, slot counter and deferred-request flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Capture of slot state for the engine, host read-before-write data and frame pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upd_cur    <= '0;
      r_upd_slot   <= '0;
      r_host_rdata <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (r_state == RD) begin
        r_upd_cur  <= i_ram_dout;
        r_upd_slot <= r_slot;
      end
      if (w_host_grant) begin
        r_host_rdata <= i_ram_dout;
      end
      r_frame_done <= (r_state == WR) && (r_slot == LAST_SLOT);
    end
  end

  // Sticky overrun; a new event in the same cycle as the clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_ovr_evt | (r_overrun & ~i_overrun_clr);
    end
  end

  assign o_upd_cur    = r_upd_cur;
  assign o_upd_slot   = r_upd_slot;
  assign o_host_ack   = (r_state == HACK);
  assign o_host_rdata = r_host_rdata;
  assign o_busy       = (r_state == RD) || (r_state == WR);
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule
